noc_input_port: RTL

- Per-direction input stage of the 5-port NoC router (L, N, E, W, S); one instance per port, directly upstream of the arbiter.
- Buffers incoming flits in a show-ahead FIFO and tracks packet framing.
- Presents flit_id, packet length and a level request to the arbiter; the crossbar pops flits when the port is granted.

---
 rtl/noc_input_port_if.sv | 28 ++
 rtl/noc_input_port.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/noc_input_port_if.sv
// Link-side and crossbar/arbiter-side signals of one NoC router input port.
// master drives the upstream flits and the pop strobe; slave is the input port itself.
interface noc_input_port_if #(
  parameter int DATA_W = 32
);
  // Handshakes: a flit moves upstream->port on a clock edge where in_valid && in_ready,
  // and port->crossbar on an edge where out_valid && out_rd; neither side waits on the other.
  logic [DATA_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_flit;
  logic              out_valid;
  logic              out_rd;
  logic [2:0]        flit_id;
  logic [11:0]       length;
  logic              req;
  logic [7:0]        err_cnt;

  modport master (
    output in_flit, in_valid, out_rd,
    input  in_ready, out_flit, out_valid, flit_id, length, req, err_cnt
  );

  modport slave (
    input  in_flit, in_valid, out_rd,
    output in_ready, out_flit, out_valid, flit_id, length, req, err_cnt
  );
endinterface

// File: rtl/noc_input_port.sv
// NoC router input port: show-ahead flit FIFO plus packet-framing FSM feeding the arbiter.
// Define INPORT_ERRCNT_EN to build the saturating dropped-flit / truncation counter.
module noc_input_port #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  noc_input_port_if.slave  io_bus,
  output logic             o_dbg_state,
  output logic [CNT_W-1:0] o_dbg_count
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [11:0]       r_length;

  logic              w_empty;
  logic              w_full;
  logic [DATA_W-1:0] w_head;
  logic [2:0]        w_head_id;
  logic              w_is_hdr;
  logic              w_is_cont;
  logic              w_is_tail;
  logic              w_push;
  logic              w_pop;
  logic              w_out_valid;
  logic              w_req;
  logic              w_drop;
  logic              w_trunc;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_id = w_head[DATA_W-1 -: 3];
  assign w_is_hdr  = !w_empty && (w_head_id == 3'b001);
  assign w_is_cont = !w_empty && ((w_head_id == 3'b010) || (w_head_id == 3'b011));
  assign w_is_tail = !w_empty && (w_head_id == 3'b011);

  // A full FIFO refuses the push even when the head is popped in the same cycle.
  assign w_push = io_bus.in_valid && io_bus.in_ready;
  assign w_pop  = (io_bus.out_rd && w_out_valid) || w_drop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_bus.in_flit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_is_hdr && io_bus.out_rd) w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_trunc)                w_state_next = ST_IDLE;
        else if (w_pop && w_is_tail) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // In ACTIVE a header or malformed head ends the packet without being offered to the crossbar.
  always_comb begin
    w_out_valid = 1'b0;
    w_req       = 1'b0;
    w_drop      = 1'b0;
    w_trunc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_out_valid = w_is_hdr;
        w_req       = w_is_hdr;
        w_drop      = !w_empty && !w_is_hdr;
      end
      ST_ACTIVE: begin
        w_req       = 1'b1;
        w_out_valid = w_is_cont;
        w_trunc     = !w_empty && !w_is_cont;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_length <= '0;
    end else if ((r_state == ST_IDLE) && w_is_hdr) begin
      r_length <= w_head[11:0];
    end
  end

`ifdef INPORT_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if ((w_drop || w_trunc) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign io_bus.err_cnt = r_err_cnt;
`else
  assign io_bus.err_cnt = 8'h00;
`endif

  assign io_bus.in_ready  = !rst && !w_full;
  assign io_bus.out_flit  = w_head;
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.flit_id   = w_empty ? 3'b000 : w_head_id;
  assign io_bus.length    = r_length;
  assign io_bus.req       = w_req;

  assign o_dbg_state = (r_state == ST_ACTIVE);
  assign o_dbg_count = r_count;

endmodule
